// File: rtl/fwrisc_shift_seq.sv
// Multi-cycle shift sequencer: drives a one-bit-per-pass ALU for shamt cycles, then offers the result.
// Latency shamt+1 cycles from accept (1 cycle for shamt==0 or non-shift ops); response holds until rsp_ready.
module fwrisc_shift_seq #(
  parameter int         SHAMT_W = 5,
  parameter logic [2:0] OP_SLL  = 3'd2,
  parameter logic [2:0] OP_SRL  = 3'd3,
  parameter logic [2:0] OP_SRA  = 3'd4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [31:0]        req_data,
  input  logic [SHAMT_W-1:0] req_shamt,
  output logic [31:0]        alu_op_a,
  output logic [31:0]        alu_op_b,
  output logic [2:0]         alu_op,
  input  logic [31:0]        alu_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        acc;
  logic [2:0]         op_r;
  logic [SHAMT_W-1:0] cnt;
  logic               is_shift;

  assign is_shift = (req_op == OP_SLL) || (req_op == OP_SRL) || (req_op == OP_SRA);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (req_shamt == '0 || !is_shift) ? DONE : SHIFT;
      SHIFT:   if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      op_r  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          acc  <= req_data;
          op_r <= req_op;
          cnt  <= req_shamt;
        end
        // Each pass feeds the ALU result back as the next operand.
        SHIFT: begin
          acc <= alu_out;
          cnt <= cnt - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign alu_op_a  = acc;
  assign alu_op_b  = '0;
  assign alu_op    = op_r;
  assign rsp_valid = (state == DONE);
  assign rsp_data  = acc;
  assign busy      = (state != IDLE);
  assign req_ready = !busy;

endmodule

// File: tb/tb_fwrisc_shift_seq.sv
// Bench for fwrisc_shift_seq: one-bit-per-pass ALU model plus arithmetic reference for result and latency.
module tb_fwrisc_shift_seq;
  localparam int         SHAMT_W = 5;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SLL  = 3'd2;
  localparam logic [2:0] OP_SRL  = 3'd3;
  localparam logic [2:0] OP_SRA  = 3'd4;

  logic               clock = 0;
  logic               reset = 1;
  logic               req_valid = 0;
  logic               req_ready;
  logic [2:0]         req_op = '0;
  logic [31:0]        req_data = '0;
  logic [SHAMT_W-1:0] req_shamt = '0;
  logic [31:0]        alu_op_a, alu_op_b, alu_out;
  logic [2:0]         alu_op;
  logic               rsp_valid;
  logic               rsp_ready = 0;
  logic [31:0]        rsp_data;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  fwrisc_shift_seq #(.SHAMT_W(SHAMT_W), .OP_SLL(OP_SLL), .OP_SRL(OP_SRL), .OP_SRA(OP_SRA)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_shamt(req_shamt),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clock = ~clock;

  // ALU stand-in: shift group moves op_a by one bit; anything else adds.
  always_comb begin
    case (alu_op)
      OP_SLL:  alu_out = alu_op_a << 1;
      OP_SRL:  alu_out = alu_op_a >> 1;
      OP_SRA:  alu_out = {alu_op_a[31], alu_op_a[31:1]};
      default: alu_out = alu_op_a + alu_op_b;
    endcase
  end

  function automatic logic [31:0] ref_data(input logic [2:0] op, input logic [31:0] d, input int sh);
    case (op)
      OP_SLL:  return d << sh;
      OP_SRL:  return d >> sh;
      OP_SRA:  return 32'($signed(d) >>> sh);
      default: return d;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input int sh);
    if (op == OP_SLL || op == OP_SRL || op == OP_SRA) return sh + 1;
    return 1;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Issue one request from IDLE with rsp_ready high; returns cycle of first rsp_valid (-1 on timeout).
  task automatic run_req(input logic [2:0] op, input logic [31:0] d, input logic [SHAMT_W-1:0] sh,
                         output int lat, output logic [31:0] dout);
    req_valid = 1; req_op = op; req_data = d; req_shamt = sh; rsp_ready = 1;
    tick;
    req_valid = 0; req_op = 3'($urandom); req_data = $urandom; req_shamt = SHAMT_W'($urandom);
    lat = -1; dout = '0;
    for (int c = 1; c <= 40; c++) begin
      if (rsp_valid) begin
        lat = c; dout = rsp_data;
        tick;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1;
    tick; tick;
    reset = 0;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_tests++; if (alu_op_a !== 32'h0) begin n_fail++; $display("FAIL reset_acc got %h exp 0", alu_op_a); end
    n_tests++; if (alu_op !== 3'h0) begin n_fail++; $display("FAIL reset_op got %h exp 0", alu_op); end
    n_tests++; if (alu_op_b !== 32'h0) begin n_fail++; $display("FAIL reset_op_b got %h exp 0", alu_op_b); end
  endtask

  task automatic test_directed;
    logic [2:0]  ops [5] = '{OP_SLL, OP_SRA, OP_SRL, OP_SLL, OP_ADD};
    logic [31:0] din [5] = '{32'h1, 32'h80000000, 32'h80000000, 32'hDEADBEEF, 32'hDEADBEEF};
    int          shs [5] = '{4, 31, 31, 0, 5};
    logic [31:0] dex [5] = '{32'h10, 32'hFFFFFFFF, 32'h1, 32'hDEADBEEF, 32'hDEADBEEF};
    int          lex [5] = '{5, 32, 32, 1, 1};
    int lat; logic [31:0] dout;
    for (int i = 0; i < 5; i++) begin
      run_req(ops[i], din[i], SHAMT_W'(shs[i]), lat, dout);
      n_tests++; if (lat != lex[i]) begin n_fail++; $display("FAIL directed%0d_latency got %0d exp %0d", i, lat, lex[i]); end
      n_tests++; if (dout !== dex[i]) begin n_fail++; $display("FAIL directed%0d_data got %h exp %h", i, dout, dex[i]); end
    end
  endtask

  task automatic test_backpressure;
    bit seen;
    req_valid = 1; req_op = OP_SRL; req_data = 32'hF0000000; req_shamt = 4; rsp_ready = 0;
    tick;
    req_valid = 0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (rsp_valid) seen = 1; else tick;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL bp_rsp_valid got timeout exp response"); end
    for (int c = 0; c < 3; c++) begin
      req_valid = 1; req_op = OP_SLL; req_data = $urandom; req_shamt = 3;
      tick;
      n_tests++; if (rsp_data !== 32'h0F000000) begin n_fail++; $display("FAIL bp_hold_data got %h exp 0f000000", rsp_data); end
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready got %b exp 0", req_ready); end
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid_hold got %b exp 1", rsp_valid); end
    end
    req_valid = 0; rsp_ready = 1;
    tick;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_req_ready got %b exp 1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_rsp_valid got %b exp 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_shift;
    int spurious = 0;
    req_valid = 1; req_op = OP_SLL; req_data = 32'h1; req_shamt = 20; rsp_ready = 1;
    tick;
    req_valid = 0;
    for (int c = 1; c < 7; c++) tick;
    n_tests++; if (alu_op_a !== 32'h40) begin n_fail++; $display("FAIL mid_acc_cycle7 got %h exp 00000040", alu_op_a); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busy); end
    reset = 1;
    tick;
    reset = 0;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_req_ready got %b exp 1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rsp_valid got %b exp 0", rsp_valid); end
    n_tests++; if (alu_op_a !== 32'h0) begin n_fail++; $display("FAIL abort_acc got %h exp 0", alu_op_a); end
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid) spurious++;
      tick;
    end
    n_tests++; if (spurious != 0) begin n_fail++; $display("FAIL abort_no_rsp got %0d responses exp 0", spurious); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] dout;
    run_req(OP_SLL, 32'h3, 2, lat, dout);
    n_tests++; if (dout !== 32'h0000000C || lat != 3) begin n_fail++; $display("FAIL b2b_first got %h lat %0d exp 0000000c lat 3", dout, lat); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", req_ready); end
    run_req(OP_SRA, 32'hFFFFFF00, 8, lat, dout);
    n_tests++; if (dout !== 32'hFFFFFFFF || lat != 9) begin n_fail++; $display("FAIL b2b_second got %h lat %0d exp ffffffff lat 9", dout, lat); end
  endtask

  task automatic test_random;
    logic [2:0] ops [4] = '{OP_SLL, OP_SRL, OP_SRA, OP_ADD};
    logic [2:0] op; logic [31:0] d; int sh; int lat; logic [31:0] dout;
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 3)];
      d  = $urandom;
      sh = $urandom_range(0, 31);
      run_req(op, d, SHAMT_W'(sh), lat, dout);
      n_tests++; if (dout !== ref_data(op, d, sh) || lat != ref_lat(op, sh)) begin
        n_fail++;
        $display("FAIL rand%0d op %0d sh %0d got %h lat %0d exp %h lat %0d",
                 i, op, sh, dout, lat, ref_data(op, d, sh), ref_lat(op, sh));
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid_shift;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fwrisc_shift_seq.md
Name: fwrisc_shift_seq

Overview:
- Multi-cycle shift sequencer for the fwrisc ALU, whose shift group moves op_a by exactly one bit per pass.
- Accepts one shift request (op, value, shift amount) and feeds the ALU for shamt consecutive cycles, writing each ALU result back as the next op_a.
- Returns the final value through a valid/ready response port.
- Sits between decode/exec control and fwrisc_alu; owns the ALU op_a/op_b/op inputs while busy.

Parameters:
- SHAMT_W, 5: width of the shift-amount field; the maximum shift is 2^SHAMT_W-1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  a request is present.
- req_ready  output  1  the sequencer can accept a request; high only in IDLE.
- req_op  input  3  ALU op code from fwrisc_defines.vh (`OP_SLL / `OP_SRL / `OP_SRA).
- req_data  input  32  value to shift.
- req_shamt  input  SHAMT_W  shift amount.
- alu_op_a  output  32  to ALU op_a; equals the accumulator register.
- alu_op_b  output  32  to ALU op_b; constant 0.
- alu_op  output  3  to ALU op; equals the latched op register.
- alu_out  input  32  combinational ALU result.
- rsp_valid  output  1  the result is available.
- rsp_ready  input  1  the consumer takes the result.
- rsp_data  output  32  result; equals the accumulator.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- States: IDLE, SHIFT, DONE. Registers: acc[31:0], op_r[2:0], cnt[SHAMT_W-1:0].
- Reset, synchronous and overriding all else:
  - state = IDLE; acc = 0; op_r = 0; cnt = 0.
  - rsp_valid = 0, busy = 0, req_ready = 1 in the cycle after reset is sampled.
  - Reset asserted in SHIFT or DONE discards the in-flight request; no response is issued.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready (the accept cycle): acc <= req_data; op_r <= req_op; cnt <= req_shamt.
  - Next state is DONE if req_shamt == 0 or req_op is not a shift-group op; otherwise SHIFT.
  - A non-shift op passes req_data through unchanged.
  - No acceptance in any other state.
- SHIFT:
  - ALU is driven with alu_op_a = acc, alu_op = op_r.
  - Each cycle: acc <= alu_out; cnt <= cnt - 1.
  - When cnt == 1 at the edge, the next state is DONE.
  - Exactly shamt ALU passes are performed.
- DONE:
  - rsp_valid = 1; rsp_data = acc.
  - On rsp_ready, next state is IDLE.
  - While rsp_ready = 0, rsp_data and all state hold indefinitely.
- Latency: with the accept cycle as cycle 0, SHIFT occupies cycles 1..shamt and rsp_valid is first high in cycle shamt+1. For shamt = 0, rsp_valid is high in cycle 1.
- Throughput: a new request can be accepted no earlier than the cycle after the response handshake. There is no bypass from DONE to accept.
- Shift semantics (from the ALU): SLL fills with 0; SRL fills with 0; SRA replicates bit 31.
  - Shifts of up to 31 are exact.
  - No wrap-around of data.
  - cnt never underflows because the DONE transition happens at cnt == 1.
- Output stability:
  - alu_op_a/alu_op change only at clock edges (registered), so the ALU input is glitch-free from this block.
  - alu_op_b is tied to 0.
- req_* inputs are ignored outside the accept cycle; changes during SHIFT have no effect.
- busy = (state != IDLE); req_ready = !busy.

Test Plan:
- SLL, req_data = 0x00000001, shamt = 4 -> 4 ALU passes; rsp_valid first high in cycle 5 after accept; rsp_data = 0x00000010.
- SRA 0x80000000 shamt = 31 -> rsp_data = 0xFFFFFFFF in cycle 32. SRL 0x80000000 shamt = 31 -> rsp_data = 0x00000001.
- shamt = 0, SLL, req_data = 0xDEADBEEF -> rsp_valid in cycle 1, rsp_data = 0xDEADBEEF, no SHIFT cycles. Same timing and data for op = `OP_ADD with shamt = 5 (pass-through).
- Backpressure: SRL 0xF0000000 shamt = 4, hold rsp_ready = 0 for 3 cycles in DONE -> rsp_data stays 0x0F000000, req_ready = 0, and a req_valid offered meanwhile is not accepted. After the rsp_ready handshake, req_ready = 1 the next cycle.
- Reset mid-SHIFT: SLL 0x1 shamt = 20, assert reset in cycle 7 -> next cycle state IDLE, acc = 0, rsp_valid = 0, req_ready = 1. No response ever appears for the aborted request.
- Back-to-back: two requests, SLL 0x3 shamt = 2 then SRA 0xFFFFFF00 shamt = 8, with rsp_ready held at 1 -> responses 0x0000000C then 0xFFFFFFFF. The second is accepted the cycle after the first handshake.
